// File: rtl/ahb_lite_master_if_pkg.sv
// rtl/ahb_lite_master_if_pkg.sv - AHB-Lite encodings, FSM states and request helpers
package ahb_lite_master_if_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  // Size code 11 has no meaning on a 32-bit bus, so it is issued as a word.
  function automatic logic [2:0] req_to_hsize(input logic [1:0] size);
    return (size == 2'b11) ? HSIZE_WORD : {1'b0, size};
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lite_master_if.sv
// rtl/ahb_lite_master_if.sv - single-outstanding AHB-Lite initiator for a load/store request port
module ahb_lite_master_if
  import ahb_lite_master_if_pkg::*;
#(
  parameter int         ADDR_WIDTH  = 32,
  parameter bit         ALIGN_CHECK = 1'b1,
  parameter logic [3:0] HPROT_VAL   = HPROT_DEFAULT
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [31:0]           HWDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  input  logic [31:0]           HRDATA
);

  state_e                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic [1:0]            htrans_q, htrans_d;
  logic                  hwrite_q, hwrite_d;
  logic [2:0]            hsize_q, hsize_d;
  logic [31:0]           hwdata_q, hwdata_d;
  logic [31:0]           wdata_q, wdata_d;

  logic accept;
  logic misaligned;

  assign accept     = req_valid && req_ready_q;
  assign misaligned = ALIGN_CHECK && is_misaligned(req_size, req_addr[1:0]);

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    haddr_d     = haddr_q;
    htrans_d    = htrans_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hwdata_d    = hwdata_q;
    wdata_d     = wdata_q;

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        if (accept) begin
          req_ready_d = 1'b0;
          wdata_d     = req_wdata;
          if (misaligned) begin
            state_d     = ST_RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d  = ST_ADDR;
            htrans_d = HTRANS_NONSEQ;
            haddr_d  = req_addr;
            hwrite_d = req_write;
            hsize_d  = req_to_hsize(req_size);
          end
        end
      end

      ST_ADDR: begin
        if (HREADY) begin
          htrans_d = HTRANS_IDLE;
          if (hwrite_q) hwdata_d = wdata_q;
          state_d = ST_DATA;
        end
      end

      // HRESP=1 with HREADY=0 is the first cycle of an error response: keep waiting.
      ST_DATA: begin
        if (HREADY) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          if (HRESP == HRESP_ERROR) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            rsp_err_d   = 1'b0;
            rsp_rdata_d = hwrite_q ? 32'h0 : HRDATA;
          end
        end
      end

      // Entered with rsp_valid low only from a local misalignment reject.
      ST_RESP: begin
        if (rsp_valid_q) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      haddr_q     <= '0;
      htrans_q    <= HTRANS_IDLE;
      hwrite_q    <= 1'b0;
      hsize_q     <= HSIZE_WORD;
      hwdata_q    <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hwdata_q    <= hwdata_d;
      wdata_q     <= wdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VAL;
  assign HWDATA    = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_master_if.sv
// tb/tb_ahb_lite_master_if.sv - self-checking bench with memory slave and reference model
module tb_ahb_lite_master_if;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_master_if #(.ADDR_WIDTH(32), .ALIGN_CHECK(1'b1), .HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  // Memory slave: wait_cfg wait states per data phase, two-cycle ERROR when HADDR[12] is set.
  logic [31:0] mem [0:63];
  logic        dp_active, dp_write, dp_err;
  logic [31:0] dp_addr;
  logic [2:0]  dp_size;
  logic [3:0]  wmask;
  int          dp_cnt;
  int          wait_cfg = 0;

  always_comb begin
    case (dp_size)
      3'b000:  wmask = 4'b0001 << dp_addr[1:0];
      3'b001:  wmask = dp_addr[1] ? 4'b1100 : 4'b0011;
      default: wmask = 4'b1111;
    endcase
  end

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = 32'h0;
    if (dp_active) begin
      if (dp_cnt < wait_cfg) HREADY = 1'b0;
      else if (dp_err) begin
        HRESP  = 1'b1;
        HREADY = (dp_cnt == wait_cfg + 1);
      end
      if (dp_err) HRDATA = 32'hBAD0BAD0;
      else if (!dp_write) HRDATA = mem[dp_addr[7:2]];
    end
  end

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_active <= 1'b0;
      dp_cnt    <= 0;
    end else begin
      if (dp_active && HREADY) begin
        dp_active <= 1'b0;
        if (dp_write && !dp_err)
          for (int b = 0; b < 4; b++)
            if (wmask[b]) mem[dp_addr[7:2]][8*b +: 8] <= HWDATA[8*b +: 8];
      end else if (dp_active) begin
        dp_cnt <= dp_cnt + 1;
      end
      if (HREADY && HTRANS == 2'b10) begin
        dp_active <= 1'b1;
        dp_cnt    <= 0;
        dp_addr   <= HADDR;
        dp_write  <= HWRITE;
        dp_size   <= HSIZE;
        dp_err    <= HADDR[12];
      end
    end
  end

  // Bus monitor
  int          nonseq_total = 0;
  int          stab_bad = 0;
  int          rsp_total = 0;
  logic [2:0]  mon_hsize;
  logic [31:0] mon_haddr;
  logic        mon_hwrite;
  logic        dp_seen = 1'b0;
  logic [31:0] dp_hw0, dp_ha0;

  always @(negedge HCLK) begin
    if (rsp_valid) rsp_total++;
    if (HTRANS == 2'b10) begin
      nonseq_total++;
      mon_hsize  = HSIZE;
      mon_haddr  = HADDR;
      mon_hwrite = HWRITE;
    end
    if (dp_active) begin
      if (!dp_seen) begin
        dp_seen = 1'b1;
        dp_hw0  = HWDATA;
        dp_ha0  = HADDR;
      end else if (HWDATA !== dp_hw0 || HADDR !== dp_ha0) begin
        stab_bad++;
      end
    end else begin
      dp_seen = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory image and the response rules.
  logic [31:0] ref_mem [0:63];

  task automatic model(input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, output logic e, output logic [31:0] rd,
                       output logic bus);
    int nbytes;
    int base;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    bus    = (a % nbytes) == 0;
    e      = !bus || a[12];
    rd     = 32'h0;
    base   = a % 4;
    if (!e) begin
      if (w) begin
        for (int b = base; b < base + nbytes; b++) ref_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
      end else begin
        rd = ref_mem[a[7:2]];
      end
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic do_req(input string tag, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d, input int waits,
                        input logic exp_err, input logic [31:0] exp_rd, input int exp_lat,
                        input logic exp_bus);
    int k;
    int ns0;
    int sb0;
    wait_cfg = waits;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge HCLK);
      k++;
    end
    if (!req_ready) begin
      chk({tag, " req_ready timeout"}, 32'd0, 32'd1);
      return;
    end
    req_valid = 1'b1;
    req_write = w;
    req_size  = sz;
    req_addr  = a;
    req_wdata = d;
    ns0 = nonseq_total;
    sb0 = stab_bad;
    @(posedge HCLK);
    @(negedge HCLK);
    req_valid = 1'b0;
    k = 1;
    while (!rsp_valid && k < 40) begin
      @(negedge HCLK);
      k++;
    end
    if (!rsp_valid) begin
      chk({tag, " rsp timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, " latency"}, k, exp_lat);
    chk({tag, " rsp_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    chk({tag, " rsp_rdata"}, rsp_rdata, exp_rd);
    chk({tag, " nonseq count"}, nonseq_total - ns0, exp_bus ? 32'd1 : 32'd0);
    if (exp_bus) begin
      chk({tag, " HSIZE"}, {29'd0, mon_hsize}, (sz == 2'd3) ? 32'd2 : {30'd0, sz});
      chk({tag, " HADDR"}, mon_haddr, a);
      chk({tag, " HWRITE"}, {31'd0, mon_hwrite}, {31'd0, w});
      chk({tag, " data-phase stability"}, stab_bad - sb0, 32'd0);
    end
    @(negedge HCLK);
    chk({tag, " rsp_valid one cycle"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
    int          waits;
    logic        e;
    logic [31:0] rd;
    int          lat;
    logic        bus;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1);
  end

  initial begin
    logic        e, bus, w;
    logic [31:0] rd, a, d;
    logic [1:0]  sz;
    int          waits, rsp0;

    tbl[0]  = '{1'b1, 2'd2, 32'h100,  32'hDEADBEEF, 0, 1'b0, 32'h0,        3, 1'b1};
    tbl[1]  = '{1'b0, 2'd2, 32'h100,  32'h0,        2, 1'b0, 32'hDEADBEEF, 5, 1'b1};
    tbl[2]  = '{1'b1, 2'd0, 32'h103,  32'hAA000000, 0, 1'b0, 32'h0,        3, 1'b1};
    tbl[3]  = '{1'b0, 2'd2, 32'h100,  32'h0,        0, 1'b0, 32'hAAADBEEF, 3, 1'b1};
    tbl[4]  = '{1'b0, 2'd1, 32'h101,  32'h0,        0, 1'b1, 32'h0,        2, 1'b0};
    tbl[5]  = '{1'b0, 2'd2, 32'h1100, 32'h0,        0, 1'b1, 32'h0,        4, 1'b1};
    tbl[6]  = '{1'b1, 2'd2, 32'h104,  32'h12345678, 1, 1'b0, 32'h0,        4, 1'b1};
    tbl[7]  = '{1'b0, 2'd2, 32'h104,  32'h0,        0, 1'b0, 32'h12345678, 3, 1'b1};
    tbl[8]  = '{1'b1, 2'd1, 32'h106,  32'hCAFE0000, 0, 1'b0, 32'h0,        3, 1'b1};
    tbl[9]  = '{1'b0, 2'd2, 32'h104,  32'h0,        3, 1'b0, 32'hCAFE5678, 6, 1'b1};
    tbl[10] = '{1'b1, 2'd2, 32'h10A,  32'h55555555, 0, 1'b1, 32'h0,        2, 1'b0};
    tbl[11] = '{1'b0, 2'd3, 32'h100,  32'h0,        0, 1'b0, 32'hAAADBEEF, 3, 1'b1};

    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end

    // Reset values
    #12;
    chk("reset HTRANS", {30'd0, HTRANS}, 32'd0);
    chk("reset HADDR", HADDR, 32'd0);
    chk("reset HWRITE", {31'd0, HWRITE}, 32'd0);
    chk("reset HSIZE", {29'd0, HSIZE}, 32'd2);
    chk("reset HWDATA", HWDATA, 32'd0);
    chk("reset req_ready", {31'd0, req_ready}, 32'd0);
    chk("reset rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("HBURST", {29'd0, HBURST}, 32'd0);
    chk("HPROT", {28'd0, HPROT}, 32'h3);

    @(negedge HCLK);
    HRESETn = 1'b1;
    #1;
    chk("req_ready before first edge", {31'd0, req_ready}, 32'd0);
    @(negedge HCLK);
    chk("req_ready after first edge", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 12; i++) begin
      model(tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].d, e, rd, bus);
      do_req($sformatf("vec%0d", i), tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].d,
             tbl[i].waits, tbl[i].e, tbl[i].rd, tbl[i].lat, tbl[i].bus);
    end

    for (int i = 0; i < 60; i++) begin
      w     = 1'($urandom_range(0, 1));
      sz    = 2'($urandom_range(0, 3));
      a     = 32'h100 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) a[12] = 1'b1;
      d     = $urandom;
      waits = $urandom_range(0, 3);
      model(w, sz, a, d, e, rd, bus);
      do_req($sformatf("rnd%0d", i), w, sz, a, d, waits, e, rd,
             bus ? (3 + waits + (e ? 1 : 0)) : 2, bus);
    end

    // Write a known non-zero HWDATA, then reset during a stalled read data phase.
    model(1'b1, 2'd2, 32'h108, 32'hA5A5F00D, e, rd, bus);
    do_req("pre-reset write", 1'b1, 2'd2, 32'h108, 32'hA5A5F00D, 0, 1'b0, 32'h0, 3, 1'b1);
    wait_cfg  = 3;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'd2;
    req_addr  = 32'h108;
    @(posedge HCLK);
    @(negedge HCLK);
    req_valid = 1'b0;
    @(negedge HCLK);
    chk("mid-reset in data phase", {31'd0, dp_active}, 32'd1);
    rsp0 = rsp_total;
    HRESETn = 1'b0;
    #1;
    chk("mid-reset HTRANS", {30'd0, HTRANS}, 32'd0);
    chk("mid-reset HADDR", HADDR, 32'd0);
    chk("mid-reset HWDATA", HWDATA, 32'd0);
    chk("mid-reset HSIZE/HWRITE", {28'd0, HSIZE, HWRITE}, 32'h4);
    chk("mid-reset req/rsp", {29'd0, req_ready, rsp_valid, rsp_err}, 32'd0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (6) @(negedge HCLK);
    chk("no rsp after reset abort", rsp_total - rsp0, 32'd0);
    for (int i = 0; i < 64; i++) mem[i] = ref_mem[i];
    model(1'b0, 2'd2, 32'h108, 32'h0, e, rd, bus);
    do_req("post-reset read", 1'b0, 2'd2, 32'h108, 32'h0, 1, 1'b0, rd, 4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
